// File: rtl/imm_gen_pipe.sv
// Registered immediate generator at the ID->EX boundary, with valid/ready handshake, flush and a sideband tag.
// Define IMM_GEN_ZIMM_EN to decode ImmSrc 110 as the CSR zimm field; otherwise 110 is reserved.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      Instr,
  input  logic [2:0]       ImmSrc,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  ImmExt,
  output logic [TAG_W-1:0] out_tag,
  output logic             imm_err
);

  localparam logic [2:0] SRC_I     = 3'b000;
  localparam logic [2:0] SRC_S     = 3'b001;
  localparam logic [2:0] SRC_B     = 3'b010;
  localparam logic [2:0] SRC_J     = 3'b011;
  localparam logic [2:0] SRC_U     = 3'b100;
  localparam logic [2:0] SRC_SHAMT = 3'b101;
  localparam logic [2:0] SRC_ZIMM  = 3'b110;

  // Returns {err, imm}; the argument keeps the instruction's own bit numbering.
  function automatic logic [XLEN:0] imm_decode(input logic [31:7] ins, input logic [2:0] src);
    logic signed [XLEN-1:0] imm;
    logic                   err;
    logic signed [11:0]     imm_i;
    logic signed [11:0]     imm_s;
    logic signed [12:0]     imm_b;
    logic signed [20:0]     imm_j;
    logic signed [31:0]     imm_u;
    logic [5:0]             shamt;
    imm_i = ins[31:20];
    imm_s = {ins[31:25], ins[11:7]};
    imm_b = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    imm_j = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    imm_u = {ins[31:12], 12'b0};
    shamt = (XLEN == 64) ? ins[25:20] : {1'b0, ins[24:20]};
    imm   = '0;
    err   = 1'b0;
    case (src)
      SRC_I:     imm = XLEN'(imm_i);
      SRC_S:     imm = XLEN'(imm_s);
      SRC_B:     imm = XLEN'(imm_b);
      SRC_J:     imm = XLEN'(imm_j);
      SRC_U:     imm = XLEN'(imm_u);
      SRC_SHAMT: imm = XLEN'(shamt);
`ifdef IMM_GEN_ZIMM_EN
      SRC_ZIMM:  imm = XLEN'(ins[19:15]);
`else
      SRC_ZIMM:  err = 1'b1;
`endif
      default:   err = 1'b1;
    endcase
    return {err, imm};
  endfunction

  logic                   r_vld_p1;
  logic signed [XLEN-1:0] r_imm_p1;
  logic [TAG_W-1:0]       r_tag_p1;
  logic                   r_err_p1;

  logic [XLEN:0]          w_dec_p0;
  logic                   w_load;

  // p0: combinational decode and handshake
  assign w_dec_p0 = imm_decode(Instr, ImmSrc);
  assign in_ready = !r_vld_p1 || out_ready;
  assign w_load   = in_valid && in_ready;

  // p1: output register; flush outranks a load, a pop without load empties the stage
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p1 <= 1'b0;
      r_imm_p1 <= '0;
      r_tag_p1 <= '0;
      r_err_p1 <= 1'b0;
    end else if (flush) begin
      r_vld_p1 <= 1'b0;
    end else if (w_load) begin
      r_vld_p1 <= 1'b1;
      r_imm_p1 <= w_dec_p0[XLEN-1:0];
      r_tag_p1 <= in_tag;
      r_err_p1 <= w_dec_p0[XLEN];
    end else if (out_ready) begin
      r_vld_p1 <= 1'b0;
    end
  end

  assign out_valid = r_vld_p1;
  assign ImmExt    = r_imm_p1;
  assign out_tag   = r_tag_p1;
  assign imm_err   = r_err_p1;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: an XLEN=32 and an XLEN=64 instance share one stimulus stream.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [24:0] Instr;
  logic [2:0]  ImmSrc;
  logic [4:0]  in_tag;
  logic        flush;
  logic        out_ready;

  logic        in_ready,  in_ready64;
  logic        out_valid, out_valid64;
  logic [31:0] ImmExt;
  logic [63:0] ImmExt64;
  logic [4:0]  out_tag,   out_tag64;
  logic        imm_err,   imm_err64;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) u_dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .Instr(Instr), .ImmSrc(ImmSrc), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .ImmExt(ImmExt),
    .out_tag(out_tag), .imm_err(imm_err)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) u_dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready64),
    .Instr(Instr), .ImmSrc(ImmSrc), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid64), .out_ready(out_ready), .ImmExt(ImmExt64),
    .out_tag(out_tag64), .imm_err(imm_err64)
  );

  typedef struct {
    logic [63:0] e32;
    logic [63:0] e64;
    logic [4:0]  tag;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference decode, written as explicit bit concatenations at 64 bits.
  function automatic logic [64:0] model(input logic [31:0] i, input logic [2:0] s, input bit x64);
    logic [63:0] v;
    logic        e;
    v = 64'd0;
    e = 1'b0;
    case (s)
      3'd0: v = {{52{i[31]}}, i[31:20]};
      3'd1: v = {{52{i[31]}}, i[31:25], i[11:7]};
      3'd2: v = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3: v = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      3'd4: v = {{32{i[31]}}, i[31:12], 12'b0};
      3'd5: v = x64 ? {58'd0, i[25:20]} : {59'd0, i[24:20]};
`ifdef IMM_GEN_ZIMM_EN
      3'd6: v = {59'd0, i[19:15]};
`else
      3'd6: e = 1'b1;
`endif
      default: e = 1'b1;
    endcase
    if (!x64) v[63:32] = 32'd0;
    return {e, v};
  endfunction

  // One clock: drive at negedge, check before the edge, update scoreboard at the edge.
  task automatic step(input bit v, input logic [31:0] ins, input logic [2:0] src,
                      input logic [4:0] tag, input bit ordy, input bit fl, input bit rst);
    exp_t  e;
    bit    pop, load;
    logic [64:0] m32, m64;
    in_valid  = v;
    Instr     = ins[31:7];
    ImmSrc    = src;
    in_tag    = tag;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    #1;
    chk("out_valid",   64'(out_valid),   64'(q.size() != 0));
    chk("out_valid64", 64'(out_valid64), 64'(q.size() != 0));
    chk("in_ready",    64'(in_ready),    64'((q.size() == 0) || ordy));
    chk("in_ready64",  64'(in_ready64),  64'((q.size() == 0) || ordy));
    if (q.size() != 0) begin
      e = q[0];
      chk("imm32",  64'(ImmExt),    e.e32);
      chk("imm64",  ImmExt64,       e.e64);
      chk("tag",    64'(out_tag),   64'(e.tag));
      chk("tag64",  64'(out_tag64), 64'(e.tag));
      chk("err",    64'(imm_err),   64'(e.err));
      chk("err64",  64'(imm_err64), 64'(e.err));
    end
    pop  = (q.size() != 0) && ordy;
    load = v && ((q.size() == 0) || ordy);
    @(posedge clk);
    if (rst || fl) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (load) begin
        m32   = model(ins, src, 1'b0);
        m64   = model(ins, src, 1'b1);
        e.e32 = m32[63:0];
        e.e64 = m64[63:0];
        e.err = m32[64];
        e.tag = tag;
        q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_state();
    chk("rst_vld",   64'(out_valid),   64'd0);
    chk("rst_vld64", 64'(out_valid64), 64'd0);
    chk("rst_imm",   64'(ImmExt),      64'd0);
    chk("rst_imm64", ImmExt64,         64'd0);
    chk("rst_tag",   64'(out_tag),     64'd0);
    chk("rst_err",   64'(imm_err),     64'd0);
    chk("rst_rdy",   64'(in_ready),    64'd1);
  endtask

  initial begin
    logic [31:0] rins;
    in_valid  = 1'b0;
    Instr     = '0;
    ImmSrc    = '0;
    in_tag    = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk_reset_state();

    // Directed formats, with literal expectations alongside the scoreboard
    step(1, 32'hFFF00093, 3'b000, 5'd1, 1, 0, 0);
    chk("I_lit", 64'(ImmExt), 64'hFFFFFFFF);
    step(1, 32'h00112223, 3'b001, 5'd2, 1, 0, 0);
    chk("S_lit", 64'(ImmExt), 64'd4);
    step(1, 32'hFE000EE3, 3'b010, 5'd3, 1, 0, 0);
    chk("B_lit", 64'(ImmExt), 64'hFFFFFFFC);
    step(1, 32'h123450B7, 3'b100, 5'd4, 1, 0, 0);
    chk("U_lit", 64'(ImmExt), 64'h12345000);
    chk("U_lit64", ImmExt64, 64'h0000000012345000);
    step(1, 32'h02800013, 3'b101, 5'd5, 1, 0, 0);
    chk("SH_lit64", ImmExt64, 64'd40);
    chk("SH_lit32", 64'(ImmExt), 64'd8);
    step(1, 32'h00088073, 3'b110, 5'd6, 1, 0, 0);
`ifdef IMM_GEN_ZIMM_EN
    chk("ZIMM_lit", 64'(ImmExt), 64'd17);
    chk("ZIMM_err", 64'(imm_err), 64'd0);
`else
    chk("ZIMM_err", 64'(imm_err), 64'd1);
    chk("ZIMM_imm", 64'(ImmExt), 64'd0);
`endif
    step(1, 32'hFFFFFFFF, 3'b111, 5'd7, 1, 0, 0);
    chk("RSV_err", 64'(imm_err), 64'd1);
    chk("RSV_imm", 64'(ImmExt), 64'd0);
    step(1, 32'h8000006F, 3'b011, 5'd8, 1, 0, 0);
    step(0, 32'h0, 3'b000, 5'd0, 1, 0, 0);

    // Stall: held entry stays put while a new one waits, then swaps in with no bubble
    step(1, 32'h00A00093, 3'b000, 5'd10, 0, 0, 0);
    repeat (3) step(1, 32'hFE000EE3, 3'b010, 5'd11, 0, 0, 0);
    step(1, 32'hFE000EE3, 3'b010, 5'd11, 1, 0, 0);
    chk("swap_tag", 64'(out_tag), 64'd11);
    step(0, 32'h0, 3'b000, 5'd0, 1, 0, 0);

    // Back-to-back, tags 1..4
    for (int k = 1; k <= 4; k++)
      step(1, 32'h00100093 + (k << 20), 3'b000, 5'(k), 1, 0, 0);
    step(0, 32'h0, 3'b000, 5'd0, 1, 0, 0);

    // Flush with an incoming entry, then flush of a held entry
    step(1, 32'h123450B7, 3'b100, 5'd20, 1, 1, 0);
    step(0, 32'h0, 3'b000, 5'd0, 0, 0, 0);
    step(1, 32'h00112223, 3'b001, 5'd21, 0, 0, 0);
    step(0, 32'h0, 3'b000, 5'd0, 0, 1, 0);
    step(0, 32'h0, 3'b000, 5'd0, 1, 0, 0);

    // Reset in the middle of a stall
    step(1, 32'hFFF00093, 3'b000, 5'd22, 0, 0, 0);
    step(1, 32'h00112223, 3'b001, 5'd23, 0, 0, 0);
    step(1, 32'h00112223, 3'b001, 5'd23, 0, 0, 1);
    chk_reset_state();

    // Random traffic with random backpressure
    for (int k = 0; k < 40; k++) begin
      rins = $urandom;
      step(bit'($urandom_range(0, 1)), rins, 3'($urandom_range(0, 7)),
           5'($urandom_range(0, 31)), bit'($urandom_range(0, 1)), 0, 0);
    end
    repeat (2) step(0, 32'h0, 3'b000, 5'd0, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
